cic_decimator: RTL and testbench
================================

CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed Q1.15).
REQ-002 SHALL have parameter DATA_FRAC, default 15, fractional bits of in/out samples.
REQ-003 SHALL have parameter N_STAGES, default 5, number of integrator/comb pairs.
REQ-004 SHALL have parameter MAX_DEC_LOG2, default 4, log2 of maximum decimation ratio (R max 16).
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port valid_in, input, 1, cic_in carries a sample this cycle (Phase-1 chain valid_out).
REQ-008 SHALL have port cic_in, input, DATA_WIDTH, signed sample (Phase-1 chain ph1_chain_out).
REQ-009 SHALL have port dec_wr_en, input, 1, load dec_sel_in and flush filter state.
REQ-010 SHALL have port dec_sel_in, input, 3, log2(R); values >4 clamp to 4.
REQ-011 SHALL have port out_gain_sel, input, 2, post-scale left shift 0..3 (x1/x2/x4/x8), sampled at output stage.
REQ-012 SHALL have port cic_out, output, DATA_WIDTH, signed decimated sample.
REQ-013 SHALL have port valid_out, output, 1, single-cycle strobe qualifying cic_out.
REQ-014 SHALL have port cic_overflow, output, 1, positive saturation on current output sample.
REQ-015 SHALL have port cic_underflow, output, 1, negative saturation on current output sample.

Function
REQ-016 SHALL hold internal accumulators of width ACC_W = DATA_WIDTH + N_STAGES*MAX_DEC_LOG2 (36 default), sign-extending cic_in.
REQ-017 SHALL update all N_STAGES cascaded integrators only on cycles with valid_in=1, using two's-complement wrap (no saturation).
REQ-018 SHALL count accepted samples modulo R = 2^k (k = latched dec_sel); the sample making count reach R-1 raises an internal decimation strobe and resets the count to 0.
REQ-019 SHALL run N_STAGES combs (differential delay 1) once per decimation strobe, on the cycle following the strobe, using the last integrator's register value.
REQ-020 SHALL scale comb output by arithmetic right shift N_STAGES*k with round-half-up, then left shift by out_gain_sel, then saturate to DATA_WIDTH signed range.
REQ-021 SHALL register cic_out/valid_out/flags so valid_out is high exactly 2 clk cycles after the edge accepting the R-th sample.
REQ-022 SHALL assert cic_overflow (cic_out=0x7FFF) or cic_underflow (cic_out=0x8000) only in the valid_out cycle of a saturated sample; both 0 otherwise.
REQ-023 SHALL keep cic_out stable between valid_out strobes.
REQ-024 SHALL, on dec_wr_en=1, latch clamp(dec_sel_in), clear integrators, combs, sample counter and pending strobes; valid_in in same cycle is dropped.
REQ-025 SHALL, with k=0 (R=1), produce valid_out for every accepted sample with cic_out equal to cic_in shifted by out_gain_sel and saturated.
REQ-026 SHALL accept back-to-back valid_in every cycle with no stall and no sample loss.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, clear integrators, combs, counter, strobes; set cic_out=0, valid_out=0, cic_overflow=0, cic_underflow=0, dec_sel=0 (R=1).
REQ-028 SHALL abort any in-flight decimation on mid-operation reset; first valid_out after release requires R new accepted samples.
REQ-029 SHALL give rst priority over dec_wr_en and valid_in.

Configuration
REQ-030 SHALL, with macro CIC_BYPASS_EN defined, add input cic_bypass (1 bit); when 1, cic_out <= cic_in and valid_out <= valid_in with 1-cycle latency, no gain, flags 0, CIC state held.
REQ-031 SHALL, without CIC_BYPASS_EN, omit the cic_bypass port and bypass logic entirely.

Verification
REQ-032 SHALL verify DC: dec_sel=3, gain 0, cic_in=0x4000 continuous -> valid_out every 8th sample; from 6th output on, cic_out=0x4000, flags 0.
REQ-033 SHALL verify saturation: dec_sel=2, out_gain_sel=3, cic_in=0x2000 DC -> settled cic_out=0x7FFF, cic_overflow=1 with each valid_out; cic_in=0xE000 -> 0x8000, cic_underflow=1.
REQ-034 SHALL verify latency: dec_sel=1, one sample 0x7FFF then zeros -> first valid_out exactly 2 cycles after 2nd accepted sample.
REQ-035 SHALL verify reconfig: dec_wr_en pulse with dec_sel_in=7 mid-stream plus valid_in same cycle -> R=16, sample dropped, next valid_out after 16 further samples.
REQ-036 SHALL verify gapped input: valid_in 1-of-3 cycles, dec_sel=2, DC 0x1000 -> one valid_out per 4 accepted samples, settled cic_out=0x1000.
REQ-037 SHALL verify reset: rst asserted 1 cycle mid-decimation -> all outputs 0 next cycle; output cadence restarts from zero count with R=1.

Source files
------------

// File: rtl/cic_if.sv
// Sample/config/result bundle for the CIC decimator.
// With CIC_BYPASS_EN defined the bundle also carries the cic_bypass control.
interface cic_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] cic_in;
    logic                  dec_wr_en;
    logic [2:0]            dec_sel_in;
    logic [1:0]            out_gain_sel;
    logic [DATA_WIDTH-1:0] cic_out;
    logic                  valid_out;
    logic                  cic_overflow;
    logic                  cic_underflow;
`ifdef CIC_BYPASS_EN
    logic                  cic_bypass;
`endif

    // Producer side: drives samples and configuration, observes results
    modport master (
`ifdef CIC_BYPASS_EN
        output cic_bypass,
`endif
        output valid_in, cic_in, dec_wr_en, dec_sel_in, out_gain_sel,
        input  cic_out, valid_out, cic_overflow, cic_underflow
    );

    // Filter side
    modport slave (
`ifdef CIC_BYPASS_EN
        input  cic_bypass,
`endif
        input  valid_in, cic_in, dec_wr_en, dec_sel_in, out_gain_sel,
        output cic_out, valid_out, cic_overflow, cic_underflow
    );
endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC decimator, runtime ratio R = 2^k (k <= MAX_DEC_LOG2), with
// bit-growth normalisation, round-half-up, post gain and saturation.
// Optional feature macro: CIC_BYPASS_EN adds a 1-cycle pass-through mode.
module cic_decimator #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DATA_FRAC    = 15,
    parameter int unsigned N_STAGES     = 5,
    parameter int unsigned MAX_DEC_LOG2 = 4
) (
    input logic  clk,
    input logic  rst,
    cic_if.slave bus
);
    localparam int unsigned ACC_W    = DATA_WIDTH + N_STAGES * MAX_DEC_LOG2;
    localparam int unsigned SC_W     = ACC_W + 4;
    localparam int unsigned CNT_W    = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
    localparam int unsigned SH_W     = 8;
    // Input and output share one Q format, so no fractional realignment.
    localparam int unsigned FRAC_ADJ = DATA_FRAC - DATA_FRAC;
    localparam logic signed [SC_W-1:0] SAT_MAX = SC_W'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic signed [SC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [2:0]              dec_sel;
    logic [2:0]              sel_clamp_c;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_last_c;
    logic                    dec_stb;
    logic                    comb_vld;
    logic signed [ACC_W-1:0] x_ext_c;
    logic signed [ACC_W-1:0] integ      [N_STAGES];
    logic signed [ACC_W-1:0] int_nxt_c  [N_STAGES];
    logic signed [ACC_W-1:0] comb_dly   [N_STAGES];
    logic signed [ACC_W-1:0] comb_c     [N_STAGES+1];
    logic signed [ACC_W-1:0] comb_out;
    logic [SH_W-1:0]         sh_c;
    logic signed [SC_W-1:0]  ext_c;
    logic signed [SC_W-1:0]  rnd_c;
    logic signed [SC_W-1:0]  scaled_c;
    logic signed [SC_W-1:0]  gained_c;
    logic                    ovf_c;
    logic                    unf_c;
    logic [DATA_WIDTH-1:0]   sat_c;

    // Ratio clamp and terminal count for the current ratio
    always_comb begin
        sel_clamp_c = (32'(bus.dec_sel_in) > MAX_DEC_LOG2) ? 3'(MAX_DEC_LOG2) : bus.dec_sel_in;
        cnt_last_c  = CNT_W'((32'd1 << dec_sel) - 32'd1);
    end

    // Integrator cascade next values (current sample ripples through all stages)
    always_comb begin
        x_ext_c      = {{(ACC_W - DATA_WIDTH){bus.cic_in[DATA_WIDTH-1]}}, bus.cic_in};
        int_nxt_c[0] = integ[0] + x_ext_c;
        for (int i = 1; i < N_STAGES; i++) begin
            int_nxt_c[i] = integ[i] + int_nxt_c[i-1];
        end
    end

    // Comb cascade, differential delay 1 at the decimated rate
    always_comb begin
        comb_c[0] = integ[N_STAGES-1];
        for (int i = 0; i < N_STAGES; i++) begin
            comb_c[i+1] = comb_c[i] - comb_dly[i];
        end
    end

    // Normalise by R^N with round-half-up, apply gain, saturate
    always_comb begin
        ext_c    = {{(SC_W - ACC_W){comb_out[ACC_W-1]}}, comb_out};
        sh_c     = SH_W'(N_STAGES * 32'(dec_sel) + FRAC_ADJ);
        rnd_c    = (sh_c == '0) ? '0 : (SC_W'(1) << (sh_c - SH_W'(1)));
        scaled_c = (ext_c + rnd_c) >>> sh_c;
        gained_c = scaled_c <<< bus.out_gain_sel;
        ovf_c    = gained_c > SAT_MAX;
        unf_c    = gained_c < SAT_MIN;
        if (ovf_c) begin
            sat_c = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (unf_c) begin
            sat_c = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            sat_c = gained_c[DATA_WIDTH-1:0];
        end
    end

    // Filter state, decimation counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_sel           <= '0;
            cnt               <= '0;
            dec_stb           <= 1'b0;
            comb_vld          <= 1'b0;
            comb_out          <= '0;
            for (int i = 0; i < N_STAGES; i++) begin
                integ[i]    <= '0;
                comb_dly[i] <= '0;
            end
            bus.cic_out       <= '0;
            bus.valid_out     <= 1'b0;
            bus.cic_overflow  <= 1'b0;
            bus.cic_underflow <= 1'b0;
        end else if (bus.dec_wr_en) begin
            dec_sel           <= sel_clamp_c;
            cnt               <= '0;
            dec_stb           <= 1'b0;
            comb_vld          <= 1'b0;
            comb_out          <= '0;
            for (int i = 0; i < N_STAGES; i++) begin
                integ[i]    <= '0;
                comb_dly[i] <= '0;
            end
            bus.valid_out     <= 1'b0;
            bus.cic_overflow  <= 1'b0;
            bus.cic_underflow <= 1'b0;
        end
`ifdef CIC_BYPASS_EN
        else if (bus.cic_bypass) begin
            bus.valid_out     <= bus.valid_in;
            bus.cic_overflow  <= 1'b0;
            bus.cic_underflow <= 1'b0;
            if (bus.valid_in) begin
                bus.cic_out <= bus.cic_in;
            end
        end
`endif
        else begin
            dec_stb <= 1'b0;
            if (bus.valid_in) begin
                for (int i = 0; i < N_STAGES; i++) begin
                    integ[i] <= int_nxt_c[i];
                end
                if (cnt == cnt_last_c) begin
                    cnt     <= '0;
                    dec_stb <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            comb_vld <= dec_stb;
            if (dec_stb) begin
                for (int i = 0; i < N_STAGES; i++) begin
                    comb_dly[i] <= comb_c[i];
                end
                comb_out <= comb_c[N_STAGES];
            end
            bus.valid_out     <= comb_vld;
            bus.cic_overflow  <= comb_vld & ovf_c;
            bus.cic_underflow <= comb_vld & unf_c;
            if (comb_vld) begin
                bus.cic_out <= sat_c;
            end
        end
    end
endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: directed steps with a scoreboard of
// expected outputs (due cycle, value, flags) pushed as samples are driven.
module tb_cic_decimator;
    localparam int unsigned DW = 16;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        ovf;
        logic        unf;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cic_if #(.DATA_WIDTH(DW)) bus ();

    cic_decimator #(
        .DATA_WIDTH  (DW),
        .DATA_FRAC   (15),
        .N_STAGES    (5),
        .MAX_DEC_LOG2(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          r_cur = 1;
    int          out_idx = 0;
    int          settle_from = 0;
    logic [1:0]  gain = 2'd0;
    bit          mon_en = 1'b0;
    logic [15:0] last_out = 16'h0;
    logic [15:0] vals[$];
    exp_t        sb[$];
    exp_t        mon_e;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference post-gain saturation: {ovf, unf, data}
    function automatic logic [17:0] sat_ref(input logic [15:0] x, input logic [1:0] g);
        int v;
        v = int'($signed(x)) <<< g;
        if (v > 32767) return {2'b10, 16'h7FFF};
        if (v < -32768) return {2'b01, 16'h8000};
        return {2'b00, 16'(v)};
    endfunction

    // Model of sample counting; the R-th sample schedules an output 2 edges later
    task automatic accept(input logic [15:0] x);
        exp_t       e;
        logic [17:0] r;
        if (acc_cnt == r_cur - 1) begin
            acc_cnt = 0;
            e.due   = cyc + 3;
            if (vals.size() > 0) begin
                e.data = vals.pop_front();
                e.ovf  = 1'b0;
                e.unf  = 1'b0;
                e.chk  = 1'b1;
            end else begin
                r      = sat_ref(x, gain);
                e.data = r[15:0];
                e.ovf  = r[17];
                e.unf  = r[16];
                e.chk  = (r_cur == 1) || (out_idx >= settle_from);
            end
            out_idx++;
            sb.push_back(e);
        end else begin
            acc_cnt++;
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] x);
        @(negedge clk);
        bus.valid_in  = v;
        bus.cic_in    = x;
        bus.dec_wr_en = 1'b0;
        if (v) accept(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_in  = 1'b0;
            bus.dec_wr_en = 1'b0;
        end
    endtask

    // Ratio/gain load; optional same-cycle sample must be dropped
    task automatic cfg(input logic [2:0] sel, input logic [1:0] g, input logic v);
        @(negedge clk);
        bus.dec_wr_en    = 1'b1;
        bus.dec_sel_in   = sel;
        bus.out_gain_sel = g;
        bus.valid_in     = v;
        bus.cic_in       = 16'h1000;
        gain    = g;
        r_cur   = 1 << ((sel > 3'd4) ? 4 : int'(sel));
        acc_cnt = 0;
        out_idx = 0;
    endtask

    // Output monitor: scheduled strobes, values, flags, and hold between strobes
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("valid_timing", 32'(bus.valid_out), 32'd1);
                if (mon_e.chk) begin
                    chk("cic_out", 32'(bus.cic_out), 32'(mon_e.data));
                    chk("overflow", 32'(bus.cic_overflow), 32'(mon_e.ovf));
                    chk("underflow", 32'(bus.cic_underflow), 32'(mon_e.unf));
                end
                last_out = bus.cic_out;
            end else begin
                chk("idle_strobe_flags", 32'({bus.valid_out, bus.cic_overflow, bus.cic_underflow}), 32'd0);
                chk("cic_out_hold", 32'(bus.cic_out), 32'(last_out));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef CIC_BYPASS_EN
        bus.cic_bypass   = 1'b0;
`endif
        bus.valid_in     = 1'b0;
        bus.cic_in       = 16'h0;
        bus.dec_wr_en    = 1'b0;
        bus.dec_sel_in   = 3'd0;
        bus.out_gain_sel = 2'd0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_cic_out", 32'(bus.cic_out), 32'd0);
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_overflow", 32'(bus.cic_overflow), 32'd0);
        chk("rst_underflow", 32'(bus.cic_underflow), 32'd0);
        last_out = 16'h0;
        mon_en   = 1'b1;

        // Default R=1 after reset: identity, back-to-back
        drive(1, 16'h1234); drive(1, 16'hC000); drive(1, 16'h7FFF);
        drive(1, 16'h8000); drive(1, 16'h0001);
        idle(4);

        // R=1 with gain x2 and x8, including exact-limit and saturating samples
        cfg(3'd0, 2'd1, 1'b0);
        drive(1, 16'h1234); drive(1, 16'h4000); drive(1, 16'hBFFF); drive(1, 16'hC000);
        idle(4);
        cfg(3'd0, 2'd3, 1'b0);
        drive(1, 16'h0FFF); drive(1, 16'h1000); drive(1, 16'hF000); drive(1, 16'hEFFF);
        idle(4);

        // DC unity gain at R=8: settled from the 6th output
        cfg(3'd3, 2'd0, 1'b0);
        settle_from = 5;
        repeat (64) drive(1, 16'h4000);
        idle(4);

        // Saturation at R=4 with gain x8, both polarities
        cfg(3'd2, 2'd3, 1'b0);
        repeat (32) drive(1, 16'h2000);
        idle(4);
        cfg(3'd2, 2'd3, 1'b0);
        repeat (32) drive(1, 16'hE000);
        idle(4);

        // Latency and impulse response at R=2
        cfg(3'd1, 2'd0, 1'b0);
        vals.push_back(16'h1400); vals.push_back(16'h2800); vals.push_back(16'h0400);
        drive(1, 16'h7FFF);
        repeat (5) drive(1, 16'h0000);
        idle(4);
        chk("impulse_consumed", 32'(vals.size()), 32'd0);

        // Mid-stream reconfiguration to sel 7 (clamps to R=16), sample dropped
        cfg(3'd2, 2'd0, 1'b0);
        settle_from = 1000;
        repeat (10) drive(1, 16'h1000);
        cfg(3'd7, 2'd0, 1'b1);
        repeat (32) drive(1, 16'h1000);
        idle(4);

        // Gapped input, 1 of 3 cycles, R=4
        cfg(3'd2, 2'd0, 1'b0);
        settle_from = 5;
        repeat (40) begin
            drive(1, 16'h1000);
            idle(2);
        end
        idle(4);

        // Reset mid-decimation, with dec_wr_en and valid_in also asserted
        settle_from = 1000;
        repeat (3) drive(1, 16'h1000);
        @(negedge clk);
        mon_en           = 1'b0;
        rst              = 1'b1;
        bus.valid_in     = 1'b1;
        bus.dec_wr_en    = 1'b1;
        bus.dec_sel_in   = 3'd4;
        @(negedge clk);
        rst           = 1'b0;
        bus.valid_in  = 1'b0;
        bus.dec_wr_en = 1'b0;
        chk("midrst_cic_out", 32'(bus.cic_out), 32'd0);
        chk("midrst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("midrst_overflow", 32'(bus.cic_overflow), 32'd0);
        chk("midrst_underflow", 32'(bus.cic_underflow), 32'd0);
        sb.delete();
        acc_cnt  = 0;
        r_cur    = 1;
        out_idx  = 0;
        last_out = 16'h0;
        mon_en   = 1'b1;
        drive(1, 16'h5555); drive(1, 16'h8001); drive(1, 16'h0000);
        idle(5);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
